freelist_ckpt: RTL and testbench

- N-wide physical-register free list for the rename stage, with checkpoint and rollback.
- Rename pops up to POP_WIDTH free physical registers per cycle. Commit pushes up to PUSH_WIDTH released registers per cycle.
- The branch unit snapshots the allocation pointer per in-flight branch, restores it on mispredict, or flushes the whole speculative state on exception.
- Generalises the fixed 2-wide free list to arbitrary lane counts with lane compaction and recovery.

---
 rtl/freelist_ckpt.sv | 114 +++++++++++
 tb/tb_freelist_ckpt.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/freelist_ckpt.sv
// Purpose: N-wide physical-register free list for rename, with branch checkpoint/rollback and flush.
// Latency: pop_reg is combinational from pop_en; pointer, queue and checkpoint updates land on the next clk edge.
// Backpressure: pop_ready drops when fewer than POP_WIDTH registers are free; a push that would overfill is dropped and flagged.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pop_en / pop_reg         per-lane allocate request / allocated register (0 on idle lanes)
//   pop_ready                at least POP_WIDTH registers free
//   push_en / push_reg       per-lane release of a committed register
//   ckpt_en / ckpt_id        snapshot the post-pop allocation pointer into a slot
//   restore_en / restore_id  roll the allocation pointer back to a slot
//   flush                    drop every speculative allocation
//   free_count               head - tail
//   overflow_err             sticky: a push would have exceeded capacity
module freelist_ckpt #(
  parameter int NUM_REGS   = 64,
  parameter int ARCH_REGS  = 32,
  parameter int POP_WIDTH  = 2,
  parameter int PUSH_WIDTH = 2,
  parameter int NUM_CKPT   = 4,
  parameter int AW         = $clog2(NUM_REGS),
  parameter int CW         = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [POP_WIDTH-1:0]             pop_en,
  output logic [POP_WIDTH-1:0][AW-1:0]     pop_reg,
  output logic                             pop_ready,
  input  logic [PUSH_WIDTH-1:0]            push_en,
  input  logic [PUSH_WIDTH-1:0][AW-1:0]    push_reg,
  input  logic                             ckpt_en,
  input  logic [CW-1:0]                    ckpt_id,
  input  logic                             restore_en,
  input  logic [CW-1:0]                    restore_id,
  input  logic                             flush,
  output logic [AW:0]                      free_count,
  output logic                             overflow_err
);

  localparam logic [AW:0] INIT_FREE = (AW+1)'(NUM_REGS - ARCH_REGS);

  logic [AW-1:0] queue     [NUM_REGS];
  logic [AW:0]   ckpt_tail [NUM_CKPT];
  logic [AW:0]   head, tail;

  logic [AW:0]   pop_cnt, push_cnt;
  logic [AW-1:0] pop_idx  [POP_WIDTH];
  logic [AW-1:0] push_idx [PUSH_WIDTH];
  logic          push_drop;
  logic [AW:0]   head_next, tail_pop, tail_next;

  // Pop lanes are compacted: each enabled lane takes the next entry after
  // those claimed by lower enabled lanes. Index arithmetic wraps in AW bits.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      pop_idx[i] = tail[AW-1:0] + pop_cnt[AW-1:0];
      pop_reg[i] = pop_en[i] ? queue[pop_idx[i]] : '0;
      pop_cnt    = pop_cnt + {{AW{1'b0}}, pop_en[i]};
    end
  end

  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < PUSH_WIDTH; j++) begin
      push_idx[j] = head[AW-1:0] + push_cnt[AW-1:0];
      push_cnt    = push_cnt + {{AW{1'b0}}, push_en[j]};
    end
  end

  assign free_count = head - tail;
  assign pop_ready  = (free_count >= (AW+1)'(POP_WIDTH));

  // Capacity check uses the pre-edge count; one extra bit so the sum cannot wrap.
  assign push_drop  = ({1'b0, free_count} + {1'b0, push_cnt}) > (AW+2)'(NUM_REGS);
  assign head_next  = push_drop ? head : head + push_cnt;

  // Pops only retire when the conservative ready condition holds.
  assign tail_pop   = pop_ready ? tail + pop_cnt : tail;

  // Flush rebuilds tail from the post-push head so exactly the non-architectural
  // registers are free again; restore jumps back to a snapshot.
  always_comb begin
    if (flush)           tail_next = head_next - INIT_FREE;
    else if (restore_en) tail_next = ckpt_tail[restore_id];
    else                 tail_next = tail_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= INIT_FREE;
      tail         <= '0;
      overflow_err <= 1'b0;
      for (int c = 0; c < NUM_CKPT; c++) ckpt_tail[c] <= '0;
      for (int q = 0; q < NUM_REGS; q++)
        queue[q] <= (q < NUM_REGS - ARCH_REGS) ? AW'(ARCH_REGS + q) : '0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      if (push_drop) overflow_err <= 1'b1;
      if (ckpt_en && !flush && !restore_en) ckpt_tail[ckpt_id] <= tail_pop;
      if (!push_drop) begin
        for (int j = 0; j < PUSH_WIDTH; j++)
          if (push_en[j]) queue[push_idx[j]] <= push_reg[j];
      end
    end
  end

  // Requesting a pop while not ready is a rename-stage protocol bug.
  always_ff @(posedge clk) begin
    if (!rst && (|pop_en)) assert (pop_ready);
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
// Directed bench for freelist_ckpt: a vector table for the main pop/checkpoint/
// restore/flush flow, plus hand sequences for drain/refill, flush reissue order,
// and a full-capacity configuration for overflow and pointer wrap.
module tb_freelist_ckpt;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default 64/32 configuration.
  logic            rst;
  logic [1:0]      pop_en;
  logic [1:0][5:0] pop_reg;
  logic            pop_ready;
  logic [1:0]      push_en;
  logic [1:0][5:0] push_reg;
  logic            ckpt_en;
  logic [1:0]      ckpt_id;
  logic            restore_en;
  logic [1:0]      restore_id;
  logic            flush;
  logic [6:0]      free_count;
  logic            overflow_err;

  freelist_ckpt dut (
    .clk(clk), .rst(rst),
    .pop_en(pop_en), .pop_reg(pop_reg), .pop_ready(pop_ready),
    .push_en(push_en), .push_reg(push_reg),
    .ckpt_en(ckpt_en), .ckpt_id(ckpt_id),
    .restore_en(restore_en), .restore_id(restore_id),
    .flush(flush), .free_count(free_count), .overflow_err(overflow_err)
  );

  // Second instance with no architectural registers: starts completely full.
  logic            rst2;
  logic [1:0]      pop_en2;
  logic [1:0][5:0] pop_reg2;
  logic            pop_ready2;
  logic [1:0]      push_en2;
  logic [1:0][5:0] push_reg2;
  logic            ckpt_en2    = 1'b0;
  logic [1:0]      ckpt_id2    = 2'd0;
  logic            restore_en2 = 1'b0;
  logic [1:0]      restore_id2 = 2'd0;
  logic            flush2      = 1'b0;
  logic [6:0]      free_count2;
  logic            overflow_err2;

  freelist_ckpt #(.ARCH_REGS(0)) dut2 (
    .clk(clk), .rst(rst2),
    .pop_en(pop_en2), .pop_reg(pop_reg2), .pop_ready(pop_ready2),
    .push_en(push_en2), .push_reg(push_reg2),
    .ckpt_en(ckpt_en2), .ckpt_id(ckpt_id2),
    .restore_en(restore_en2), .restore_id(restore_id2),
    .flush(flush2), .free_count(free_count2), .overflow_err(overflow_err2)
  );

  typedef struct {
    bit       r;
    bit [1:0] pe;
    bit [1:0] we;
    int       w0, w1;
    bit       ck;
    int       ckid;
    bit       rs;
    int       rsid;
    bit       fl;
    bit       cp;      // check pop_reg before the edge
    int       p1, p0;  // expected pop_reg lanes
    int       fc;      // expected free_count after the edge
    bit       rdy;     // expected pop_ready after the edge
    bit       ovf;     // expected overflow_err after the edge
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit [1:0] pe, bit [1:0] we, int w0, int w1,
                              bit ck, int ckid, bit rs, int rsid, bit fl,
                              bit cp, int p1, int p0, int fc, bit rdy, bit ovf);
    vec_t v;
    v.r = r; v.pe = pe; v.we = we; v.w0 = w0; v.w1 = w1;
    v.ck = ck; v.ckid = ckid; v.rs = rs; v.rsid = rsid; v.fl = fl;
    v.cp = cp; v.p1 = p1; v.p0 = p0; v.fc = fc; v.rdy = rdy; v.ovf = ovf;
    return v;
  endfunction

  // Called at a falling edge: drive, check combinational pops, clock, check state.
  task automatic step(input vec_t v, input string nm);
    rst = v.r; pop_en = v.pe; push_en = v.we;
    push_reg[0] = 6'(v.w0); push_reg[1] = 6'(v.w1);
    ckpt_en = v.ck; ckpt_id = 2'(v.ckid);
    restore_en = v.rs; restore_id = 2'(v.rsid); flush = v.fl;
    #1;
    if (v.cp) begin
      chk({nm, ".p0"}, int'(pop_reg[0]), v.p0);
      chk({nm, ".p1"}, int'(pop_reg[1]), v.p1);
    end
    @(posedge clk); #1;
    chk({nm, ".free"}, int'(free_count), v.fc);
    chk({nm, ".rdy"},  int'(pop_ready), int'(v.rdy));
    chk({nm, ".ovf"},  int'(overflow_err), int'(v.ovf));
    @(negedge clk);
  endtask

  task automatic step2(input bit r, input bit [1:0] pe, input bit [1:0] we,
                       input int w0, input int w1, input bit cp, input int p1,
                       input int p0, input int fc, input bit rdy, input bit ovf,
                       input string nm);
    rst2 = r; pop_en2 = pe; push_en2 = we;
    push_reg2[0] = 6'(w0); push_reg2[1] = 6'(w1);
    #1;
    if (cp) begin
      chk({nm, ".p0"}, int'(pop_reg2[0]), p0);
      chk({nm, ".p1"}, int'(pop_reg2[1]), p1);
    end
    @(posedge clk); #1;
    chk({nm, ".free"}, int'(free_count2), fc);
    chk({nm, ".rdy"},  int'(pop_ready2), int'(rdy));
    chk({nm, ".ovf"},  int'(overflow_err2), int'(ovf));
    @(negedge clk);
  endtask

  // Value sitting at queue index idx in the flush sequence: the reset contents
  // below 32, then the five registers released before and during the flush.
  function automatic int flush_q(int idx);
    return (idx < 32) ? idx + 32 : idx - 31;
  endfunction

  vec_t tbl [18];

  initial begin
    rst = 1'b1; pop_en = '0; push_en = '0; push_reg = '0;
    ckpt_en = 1'b0; ckpt_id = '0; restore_en = 1'b0; restore_id = '0; flush = 1'b0;
    rst2 = 1'b1; pop_en2 = '0; push_en2 = '0; push_reg2 = '0;

    //            r  pe     we     w0 w1  ck id rs id fl cp p1 p0  fc rdy ovf
    tbl[0]  = mk(1, 2'b00, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  32, 1, 0);
    tbl[1]  = mk(0, 2'b11, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 33, 32, 30, 1, 0);
    tbl[2]  = mk(1, 2'b00, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  32, 1, 0);
    tbl[3]  = mk(0, 2'b10, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 32, 0,  31, 1, 0);
    tbl[4]  = mk(0, 2'b01, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 0, 33,  30, 1, 0);
    tbl[5]  = mk(0, 2'b11, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 35, 34, 28, 1, 0);
    // slot 2 <- tail 4
    tbl[6]  = mk(0, 2'b00, 2'b00, 0, 0,  1, 2, 0, 0, 0, 1, 0, 0,   28, 1, 0);
    // slot 1 <- post-pop tail 6
    tbl[7]  = mk(0, 2'b11, 2'b00, 0, 0,  1, 1, 0, 0, 0, 1, 37, 36, 26, 1, 0);
    tbl[8]  = mk(0, 2'b11, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 39, 38, 24, 1, 0);
    tbl[9]  = mk(0, 2'b11, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 41, 40, 22, 1, 0);
    // restore slot 2 with one push; the same-cycle pops are discarded
    tbl[10] = mk(0, 2'b11, 2'b01, 7, 0,  0, 0, 1, 2, 0, 1, 43, 42, 29, 1, 0);
    tbl[11] = mk(0, 2'b11, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 37, 36, 27, 1, 0);
    // restore slot 1 (tail 6); the checkpoint into slot 2 must be ignored
    tbl[12] = mk(0, 2'b00, 2'b00, 0, 0,  1, 2, 1, 1, 0, 1, 0, 0,   27, 1, 0);
    tbl[13] = mk(0, 2'b00, 2'b00, 0, 0,  0, 0, 1, 2, 0, 0, 0, 0,   29, 1, 0);
    // flush beats pop, checkpoint and restore; two pushes still land
    tbl[14] = mk(0, 2'b11, 2'b11, 9, 10, 1, 2, 1, 1, 1, 1, 37, 36, 32, 1, 0);
    tbl[15] = mk(0, 2'b11, 2'b00, 0, 0,  0, 0, 0, 0, 0, 1, 36, 35, 30, 1, 0);
    // slot 2 survived the flush-cycle checkpoint
    tbl[16] = mk(0, 2'b00, 2'b00, 0, 0,  0, 0, 1, 2, 0, 0, 0, 0,   31, 1, 0);
    tbl[17] = mk(0, 2'b11, 2'b10, 0, 12, 0, 0, 0, 0, 0, 1, 37, 36, 30, 1, 0);

    @(negedge clk);
    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("row%0d", i));

    // Drain to two, then simultaneous push/pop: the pushed register is not bypassed.
    step(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 1, 0), "drain.rst");
    for (int k = 0; k < 15; k++)
      step(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 33 + 2*k, 32 + 2*k, 30 - 2*k, 1, 0),
           $sformatf("drain.pop%0d", k));
    step(mk(0, 2'b11, 2'b01, 5, 0,   0, 0, 0, 0, 0, 1, 63, 62, 1, 0, 0), "drain.pushpop");
    step(mk(0, 2'b00, 2'b01, 6, 0,   0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0), "drain.refill");
    step(mk(0, 2'b11, 2'b00, 0, 0,   0, 0, 0, 0, 0, 1, 6, 5,   0, 0, 0), "drain.reuse");
    step(mk(0, 2'b00, 2'b11, 20, 21, 0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0), "drain.push2");
    step(mk(0, 2'b11, 2'b00, 0, 0,   0, 0, 0, 0, 0, 1, 21, 20, 0, 0, 0), "drain.pop2");

    // Ten pops, three releases (lane-1-only push compacts to the next slot), then flush.
    step(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 1, 0), "fl.rst");
    for (int k = 0; k < 5; k++)
      step(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 33 + 2*k, 32 + 2*k, 30 - 2*k, 1, 0),
           $sformatf("fl.pop%0d", k));
    step(mk(0, 2'b00, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,   24, 1, 0), "fl.push12");
    step(mk(0, 2'b00, 2'b10, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0,   25, 1, 0), "fl.push3");
    step(mk(0, 2'b11, 2'b11, 4, 5, 0, 0, 0, 0, 1, 1, 43, 42, 32, 1, 0), "fl.flush");
    for (int k = 0; k < 16; k++)
      step(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1,
              flush_q(6 + 2*k), flush_q(5 + 2*k), 30 - 2*k, (k < 15), 0),
           $sformatf("fl.reissue%0d", k));
    pop_en = '0; push_en = '0; flush = 1'b0;

    // Full-capacity instance: dropped pushes, sticky error, pointer wrap.
    step2(1, 2'b00, 2'b00, 0, 0,  0, 0, 0,  64, 1, 0, "ov.rst");
    step2(0, 2'b00, 2'b01, 3, 0,  0, 0, 0,  64, 1, 1, "ov.drop");
    step2(0, 2'b00, 2'b00, 0, 0,  0, 0, 0,  64, 1, 1, "ov.sticky");
    step2(0, 2'b01, 2'b00, 0, 0,  1, 0, 0,  63, 1, 1, "ov.pop");
    step2(0, 2'b00, 2'b11, 8, 9,  0, 0, 0,  63, 1, 1, "ov.drop2");
    step2(0, 2'b00, 2'b01, 50, 0, 0, 0, 0,  64, 1, 1, "ov.fill");
    for (int k = 0; k < 31; k++)
      step2(0, 2'b11, 2'b00, 0, 0, 1, 2 + 2*k, 1 + 2*k, 62 - 2*k, 1, 1,
            $sformatf("ov.pop%0d", k));
    step2(0, 2'b11, 2'b00, 0, 0,  1, 50, 63, 0, 0, 1, "ov.wrap");
    step2(1, 2'b00, 2'b00, 0, 0,  0, 0, 0,  64, 1, 0, "ov.clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
